// File: rtl/packet_dispatch_ctrl.sv
// Ingress controller for the 3-channel router: parses header/payload/CRC, pushes to the matched FIFO, commits or flushes at packet end.
// Optional: define PKT_STATS_EN to add drop_cnt / crc_err_cnt statistics outputs.
module packet_dispatch_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_SIZE  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_req,
    output logic                  data_in_ack,
    output logic [2:0]            fifo_push,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic [2:0]            fifo_full,
    output logic [2:0]            fifo_wr_ptr_upd,
    output logic [2:0]            fifo_flush,
    input  logic [1:0]            ch0_addr,
    input  logic [1:0]            ch1_addr,
    input  logic [1:0]            ch2_addr,
    input  logic                  crc_en,
    output logic                  busy
`ifdef PKT_STATS_EN
    ,
    output logic [7:0]            drop_cnt,
    output logic [7:0]            crc_err_cnt
`endif
);

    localparam int unsigned N_CH   = 3;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CRC_W  = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        HDR = 2'd0,
        PAY = 2'd1,
        CRC = 2'd2,
        END = 2'd3
    } state_t;

    state_t                 state_q;
    logic [N_CH-1:0]        ch_oh_q;      // latched target, all-zero means drop mode
    logic [DATA_SIZE-1:0]   rem_q;
    logic                   crc_en_q;
    logic [CRC_W-1:0]       crc_q;
    logic [N_CH-1:0]        upd_q;
    logic [N_CH-1:0]        flush_q;

    logic [ADDR_W-1:0]      hdr_addr;
    logic [DATA_SIZE-1:0]   hdr_len;
    logic [N_CH-1:0]        hdr_oh;
    logic [N_CH-1:0]        tgt_oh;
    logic                   ack;
    logic                   xfer;
    logic                   crc_ok;

    // CRC-8 (poly 0x07), MSB-first, one byte per call
    function automatic logic [CRC_W-1:0] crc8_upd(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_WIDTH-1:0] d);
        logic [CRC_W-1:0] r;
        r = c ^ CRC_W'(d);
        for (int i = 0; i < 8; i++) begin
            if (r[CRC_W-1]) r = (r << 1) ^ CRC_POLY;
            else            r = r << 1;
        end
        return r;
    endfunction

    assign hdr_addr = data_in[DATA_WIDTH-1 -: ADDR_W];
    assign hdr_len  = data_in[DATA_SIZE-1:0];
    assign crc_ok   = (CRC_W'(data_in) == crc_q);

    // Address match, ch0 has highest priority
    always_comb begin
        hdr_oh = '0;
        if      (ch0_addr == hdr_addr) hdr_oh = 3'b001;
        else if (ch1_addr == hdr_addr) hdr_oh = 3'b010;
        else if (ch2_addr == hdr_addr) hdr_oh = 3'b100;
    end

    // Handshake and zero-latency push; ack never looks at data_in_req
    always_comb begin
        tgt_oh = '0;
        ack    = 1'b0;
        case (state_q)
            HDR: begin
                tgt_oh = hdr_oh;
                ack    = (hdr_oh == '0) || ((fifo_full & hdr_oh) == '0);
            end
            PAY: begin
                tgt_oh = ch_oh_q;
                ack    = (ch_oh_q == '0) || ((fifo_full & ch_oh_q) == '0);
            end
            CRC:     ack = 1'b1;
            default: ack = 1'b0;
        endcase
        ack = ack & rst_n;
        xfer = data_in_req & ack;
    end

    assign data_in_ack     = ack;
    assign fifo_push       = (xfer && (state_q == HDR || state_q == PAY)) ? tgt_oh : '0;
    assign fifo_data_in    = (fifo_push != '0) ? data_in : '0;
    assign fifo_wr_ptr_upd = upd_q;
    assign fifo_flush      = flush_q;
    assign busy            = (state_q != HDR);

    // Packet FSM with registered commit/flush pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HDR;
            ch_oh_q  <= '0;
            rem_q    <= '0;
            crc_en_q <= 1'b0;
            crc_q    <= '0;
            upd_q    <= '0;
            flush_q  <= '0;
        end else begin
            upd_q   <= '0;
            flush_q <= '0;
            case (state_q)
                HDR: begin
                    if (xfer) begin
                        ch_oh_q  <= hdr_oh;
                        rem_q    <= hdr_len;
                        crc_en_q <= crc_en;
                        crc_q    <= crc8_upd('0, data_in);
                        if (hdr_len != '0) begin
                            state_q <= PAY;
                        end else if (crc_en) begin
                            state_q <= CRC;
                        end else begin
                            state_q <= END;
                            upd_q   <= hdr_oh;
                        end
                    end
                end
                PAY: begin
                    if (xfer) begin
                        rem_q <= rem_q - DATA_SIZE'(1);
                        crc_q <= crc8_upd(crc_q, data_in);
                        if (rem_q == DATA_SIZE'(1)) begin
                            if (crc_en_q) begin
                                state_q <= CRC;
                            end else begin
                                state_q <= END;
                                upd_q   <= ch_oh_q;
                            end
                        end
                    end
                end
                CRC: begin
                    if (xfer) begin
                        state_q <= END;
                        if (crc_ok) upd_q   <= ch_oh_q;
                        else        flush_q <= ch_oh_q;
                    end
                end
                default: state_q <= HDR;
            endcase
        end
    end

`ifdef PKT_STATS_EN
    // Saturating per-packet statistics, updated in END
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt    <= '0;
            crc_err_cnt <= '0;
        end else if (state_q == END) begin
            if (ch_oh_q == '0 && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (flush_q != '0 && crc_err_cnt != 8'hFF)
                crc_err_cnt <= crc_err_cnt + 8'd1;
        end
    end
`endif

endmodule
